mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nreset  input  1  reset; reset nreset, synchronous, active-low; clock clk.
REQ-005 SHALL have ports core_req/core_we  input  1  processor-core access request / write qualifier.
REQ-006 SHALL have ports core_addr  input  ADDR_W and core_wdata  input  DATA_W  core access address / write data.
REQ-007 SHALL have ports host_req/host_we  input  1  program-loader access request / write qualifier.
REQ-008 SHALL have ports host_addr  input  ADDR_W and host_wdata  input  DATA_W  loader access address / write data.
REQ-009 SHALL have ports core_ack/host_ack  output  1  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data shared by both requesters.
REQ-011 SHALL have ports mem_en/mem_we  output  1  single-port synchronous memory enable / write strobe.
REQ-012 SHALL have ports mem_addr  output  ADDR_W and mem_wdata  output  DATA_W  memory address / write data.
REQ-013 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en.
REQ-014 SHALL have port host_owns  output  1  high from grant to ack of a host transaction.

Function
REQ-015 SHALL implement states IDLE, ACCESS, CAPTURE, ACK; one transaction per pass; re-arbitrate on every return to IDLE.
REQ-016 IDLE: if any req high at the edge, latch winner id, we, addr, wdata into internal registers and go to ACCESS; else remain IDLE.
REQ-017 ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values; next state CAPTURE.
REQ-018 CAPTURE: mem_en=0; on a read, rdata loads mem_rdata at the closing edge; on a write, rdata is unchanged; next state ACK.
REQ-019 ACK: winner's ack=1 for exactly this cycle, other ack=0; next state IDLE.
REQ-020 Latency: req sampled high in IDLE at edge N -> mem_en during cycle N+1 -> ack during cycle N+3; back-to-back throughput one access per 4 cycles.
REQ-021 Requester SHALL hold req, we, addr, wdata stable until ack; arbiter samples them only in IDLE, so later changes do not affect the transaction in flight.
REQ-022 Requester dropping req mid-transaction: transaction SHALL complete and ack SHALL still pulse.
REQ-023 mem_en, mem_we, both acks SHALL be 0 in every state other than listed above; mem_addr/mem_wdata hold latched values.
REQ-024 rdata SHALL hold its last loaded value until the next read CAPTURE.

Reset
REQ-025 nreset low at an edge SHALL force IDLE, last-grant=core, latched registers 0, rdata=0, host_owns=0; all outputs 0 next cycle.
REQ-026 Reset mid-transaction SHALL abandon it with no ack and no further mem_en; a write already issued in ACCESS is not undone.

Configuration
REQ-027 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the simultaneous-request policy.
REQ-028 Defined: on simultaneous core_req and host_req in IDLE, grant the requester not granted last; last-grant updates on every grant.
REQ-029 Undefined: host always wins simultaneous requests; last-grant register is not implemented.
REQ-030 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-031 Core read addr 0x05, mem[0x05]=0xA7 -> mem_en cycle N+1 addr 0x05 we=0, core_ack cycle N+3, rdata=0xA7.
REQ-032 Host write addr 0x10 data 0x2B then core read 0x10 -> mem_we=1 once, host_owns high 3 cycles, core rdata=0x2B.
REQ-033 Both req held high 4 transactions: macro undefined -> grants H,H,H,H; macro defined -> H,C,H,C.
REQ-034 nreset low during CAPTURE of a core read -> no core_ack, rdata=0, state IDLE, next access starts normally.
REQ-035 core_req dropped during ACCESS -> core_ack still pulses cycle N+3; host write of 0xFF after it leaves rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (core, host loader) arbiter in front of a
// single-port synchronous memory. Each granted transaction walks
// IDLE -> ACCESS -> CAPTURE -> ACK and the arbiter re-arbitrates on every
// return to IDLE.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; left undefined, the host always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              core_ack,
  output logic              host_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              host_owns
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_host_q;   // 1: host owns the transaction in flight
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                grant;          // a request is accepted at this edge
  logic                grant_host;     // the accepted request is the host's
  logic                host_pref;      // host wins if both request together

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_host_q;                   // 1: most recent grant went to the host

  assign host_pref = ~last_host_q;

  // Remember who was granted last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      last_host_q <= 1'b0;
    end else if (grant) begin
      last_host_q <= grant_host;
    end
  end
`else
  assign host_pref = 1'b1;
`endif

  // Next-state and arbitration: requests are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_host = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req || host_req) begin
          grant      = 1'b1;
          grant_host = host_req & (~core_req | host_pref);
          state_d    = ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Snapshot the winner's request so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      owner_host_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (grant) begin
      owner_host_q <= grant_host;
      we_q         <= grant_host ? host_we    : core_we;
      addr_q       <= grant_host ? host_addr  : core_addr;
      wdata_q      <= grant_host ? host_wdata : core_wdata;
    end
  end

  // Read data register: loads only at the end of a read's CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rdata_q <= '0;
    end else if (state_q == CAPTURE && !we_q) begin
      rdata_q <= mem_rdata;
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    core_ack  = 1'b0;
    host_ack  = 1'b0;
    host_owns = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        host_owns = owner_host_q;
      end
      CAPTURE: begin
        host_owns = owner_host_q;
      end
      ACK: begin
        core_ack  = ~owner_host_q;
        host_ack  = owner_host_q;
        host_owns = owner_host_q;
      end
      default: begin
      end
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata;
  logic          core_ack, host_ack, mem_en, mem_we, host_owns;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .nreset(nreset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .core_ack(core_ack), .host_ack(host_ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .host_owns(host_owns)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one transaction at a time, timed from its grant edge.
  bit            m_active;
  int            m_gedge;
  bit            m_host;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_pend;
  bit            m_last_host;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] env_mem [256];

  int n_core_ack, n_host_ack, n_we, n_owns;
  bit first_seen, first_host;

  bit            r_req   [2];
  bit            r_we    [2];
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int phase();
    return m_active ? (cyc - m_gedge) : 0;
  endfunction

  task automatic check_outputs();
    int d;
    d = phase();
    check_eq("mem_en",    32'(mem_en),    32'(d == 1));
    check_eq("mem_we",    32'(mem_we),    32'(d == 1 && m_we));
    check_eq("core_ack",  32'(core_ack),  32'(d == 3 && !m_host));
    check_eq("host_ack",  32'(host_ack),  32'(d == 3 && m_host));
    check_eq("host_owns", 32'(host_owns), 32'(d >= 1 && m_host));
    check_eq("mem_addr",  32'(mem_addr),  32'(m_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check_eq("rdata",     32'(rdata),     32'(m_rdata));
  endtask

  task automatic model_edge();
    bit win_host;
    int d;
    if (!nreset) begin
      m_active    = 1'b0;
      m_we        = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_rdata     = '0;
      m_last_host = 1'b0;
    end else if (m_active) begin
      d = phase();
      if (d == 2 && !m_we) m_rdata = m_pend;
      if (d == 3) m_active = 1'b0;
    end else if (core_req || host_req) begin
      if (core_req && host_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_host = !m_last_host;
`else
        win_host = 1'b1;
`endif
      end else begin
        win_host = host_req;
      end
      m_active = 1'b1;
      m_gedge  = cyc;
      m_host   = win_host;
      m_we     = win_host ? host_we    : core_we;
      m_addr   = win_host ? host_addr  : core_addr;
      m_wdata  = win_host ? host_wdata : core_wdata;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_pend = ref_mem[m_addr];
      m_last_host = win_host;
    end
  endtask

  // One clock cycle: check outputs, advance model, then let the memory respond.
  task automatic tick();
    logic          en_s, we_s;
    logic [AW-1:0] a_s;
    logic [DW-1:0] w_s;
    check_outputs();
    if (core_ack === 1'b1)  n_core_ack++;
    if (host_ack === 1'b1)  n_host_ack++;
    if (mem_we === 1'b1)    n_we++;
    if (host_owns === 1'b1) n_owns++;
    if (!first_seen && (core_ack === 1'b1 || host_ack === 1'b1)) begin
      first_seen = 1'b1;
      first_host = host_ack;
    end
    if (m_active && phase() == 3)
      $display("txn cycle %0d: %s %s addr=%02h data=%02h", cyc, m_host ? "host" : "core",
               m_we ? "write" : "read ", m_addr, m_we ? m_wdata : m_pend);
    en_s = mem_en; we_s = mem_we; a_s = mem_addr; w_s = mem_wdata;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (en_s === 1'b1) begin
      mem_rdata = env_mem[a_s];
      if (we_s === 1'b1) env_mem[a_s] = w_s;
    end
    @(negedge clk);
  endtask

  task automatic clear_counts();
    n_core_ack = 0; n_host_ack = 0; n_we = 0; n_owns = 0; first_seen = 1'b0; first_host = 1'b0;
  endtask

  task automatic new_txn(input int i);
    r_req[i]   = 1'b1;
    r_we[i]    = 1'($urandom_range(0, 1));
    r_addr[i]  = AW'($urandom_range(0, 15));
    r_wdata[i] = DW'($urandom);
  endtask

  initial begin
    nreset = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'(i) ^ 8'h3C;
      env_mem[i] = DW'(i) ^ 8'h3C;
    end
    ref_mem[8'h05] = 8'hA7;
    env_mem[8'h05] = 8'hA7;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
    end
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_edge();
    nreset = 1'b1;

    // Reset state, then core read of 0x05.
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h05;
    tick();
    check_eq("rd05_en_n1", 32'(mem_en), 32'd1);
    check_eq("rd05_addr",  32'(mem_addr), 32'h05);
    tick();
    tick();
    check_eq("rd05_ack_n3", 32'(core_ack), 32'd1);
    check_eq("rd05_rdata",  32'(rdata), 32'hA7);
    core_req = 1'b0;
    tick();

    // Host write 0x2B to 0x10, then core read back.
    clear_counts();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h2B;
    repeat (3) tick();
    host_req = 1'b0;
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    repeat (3) tick();
    check_eq("wr10_rdata", 32'(rdata), 32'h2B);
    core_req = 1'b0;
    tick();
    check_eq("wr10_we_cnt",   32'(n_we), 32'd1);
    check_eq("wr10_owns_cnt", 32'(n_owns), 32'd3);

    // Both requesters held for four transactions, from a fresh reset.
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    clear_counts();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h01;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h02;
    repeat (16) tick();
    core_req = 1'b0; host_req = 1'b0;
    tick();
    check_eq("tie_first_host", 32'(first_host), 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check_eq("tie_host_cnt", 32'(n_host_ack), 32'd2);
    check_eq("tie_core_cnt", 32'(n_core_ack), 32'd2);
`else
    check_eq("tie_host_cnt", 32'(n_host_ack), 32'd4);
    check_eq("tie_core_cnt", 32'(n_core_ack), 32'd0);
`endif

    // Reset during CAPTURE of a core read abandons it.
    clear_counts();
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    tick();
    tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1; core_req = 1'b0;
    check_eq("rst_no_ack", 32'(core_ack), 32'd0);
    check_eq("rst_rdata",  32'(rdata), 32'd0);
    check_eq("rst_no_en",  32'(mem_en), 32'd0);
    repeat (2) tick();
    core_req = 1'b1; core_addr = 8'h05;
    tick();
    check_eq("rst_next_en", 32'(mem_en), 32'd1);
    tick();
    tick();
    check_eq("rst_next_ack",   32'(core_ack), 32'd1);
    check_eq("rst_next_rdata", 32'(rdata), 32'hA7);
    core_req = 1'b0;
    tick();
    check_eq("rst_ack_cnt", 32'(n_core_ack), 32'd1);

    // core_req dropped during ACCESS; then a host write leaves rdata alone.
    core_req = 1'b1; core_addr = 8'h05;
    tick();
    core_req = 1'b0;
    tick();
    tick();
    check_eq("drop_ack_n3", 32'(core_ack), 32'd1);
    check_eq("drop_rdata",  32'(rdata), 32'hA7);
    tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'hFF;
    repeat (3) tick();
    check_eq("wrff_ack",   32'(host_ack), 32'd1);
    check_eq("wrff_rdata", 32'(rdata), 32'hA7);
    host_req = 1'b0;
    tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        bit mine;
        int d;
        mine = m_active && (m_host == (i == 1));
        d    = phase();
        if (mine && d == 3) begin
          r_req[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) new_txn(i);
        end else if (mine) begin
          if ($urandom_range(0, 3) == 0) begin
            r_we[i]    = 1'($urandom_range(0, 1));
            r_addr[i]  = AW'($urandom);
            r_wdata[i] = DW'($urandom);
          end
          if ($urandom_range(0, 7) == 0) r_req[i] = 1'b0;
        end else if (!r_req[i]) begin
          if ($urandom_range(0, 2) == 0) new_txn(i);
        end
      end
      core_req = r_req[0]; core_we = r_we[0]; core_addr = r_addr[0]; core_wdata = r_wdata[0];
      host_req = r_req[1]; host_we = r_we[1]; host_addr = r_addr[1]; host_wdata = r_wdata[1];
      nreset = ($urandom_range(0, 249) != 0);
      tick();
    end
    nreset = 1'b1;
    core_req = 1'b0; host_req = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
